icache_nway: RTL and testbench

ICACHE_NWAY -- requirements
Module: icache_nway

---
 rtl/icache_nway.sv | 274 +++++++++++++++++++++++++++
 tb/tb_icache_nway.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_nway.sv
// ---------------------------------------------------------------------------
// icache_nway
// N-way set-associative, read-only instruction cache with per-set age-based
// LRU replacement. A miss fills a whole line from the next level, one word
// per mem_ack. The fill runs in order from word 0 to the last word.
//
// Ports
//   clk        single clock; all state updates on the rising edge
//   reset      asynchronous active-high reset
//   cpu_rd     CPU fetch request
//   cpu_addr   fetch word address {tag, index, word offset}
//   cpu_dout   fetched word; all ones when there is no hit
//   cpu_hit    combinational hit indication for cpu_addr
//   cpu_stall  the CPU must hold cpu_rd/cpu_addr while this is high
//   flush      invalidate every line
//   mem_req    word fetch request to the next level (high while filling)
//   mem_addr   word address being fetched
//   mem_ack    mem_data is valid this cycle
//   mem_data   fill word
//   hit_count  hit performance counter
//   miss_count miss performance counter
//
// Build option
//   ICACHE_PERF_CNT_EN  when defined, hit_count and miss_count are live
//                       32-bit counters. Otherwise both outputs are tied to
//                       0 and no counter registers are built.
// ---------------------------------------------------------------------------
module icache_nway #(
    parameter int ADDR_SIZE      = 14,
    parameter int WORD_SIZE      = 32,
    parameter int WAYS           = 2,
    parameter int LINES_PER_SET  = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_rd,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    output logic [WORD_SIZE-1:0] cpu_dout,
    output logic                 cpu_hit,
    output logic                 cpu_stall,
    input  logic                 flush,
    output logic                 mem_req,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES_PER_SET);
    localparam int TAG_W = ADDR_SIZE - OFF_W - IDX_W;
    localparam int AGE_W = $clog2(WAYS);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [AGE_W-1:0] OLDEST    = AGE_W'(WAYS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t state, state_next;

    logic [TAG_W-1:0] cpu_tag;
    logic [IDX_W-1:0] cpu_idx;
    logic [OFF_W-1:0] cpu_off;

    // Storage. Tags and data carry no reset; valid bits and ages do.
    logic [TAG_W-1:0]     tag_mem  [WAYS][LINES_PER_SET];
    logic [WORD_SIZE-1:0] data_mem [WAYS][LINES_PER_SET*WORDS_PER_LINE];
    logic [LINES_PER_SET-1:0] valid [WAYS];
    logic [AGE_W-1:0]     age      [WAYS][LINES_PER_SET];

    // Fill bookkeeping.
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [OFF_W-1:0] fill_cnt;
    logic [AGE_W-1:0] victim_way;
    logic             flush_pending;

    logic             hit_any;
    logic [AGE_W-1:0] hit_way;
    logic [AGE_W-1:0] victim_sel;
    logic             victim_found;
    logic             hit_access;
    logic             start_fill;
    logic             fill_done;
    logic             touch_en;
    logic [AGE_W-1:0] touch_way;
    logic [IDX_W-1:0] touch_idx;

    assign cpu_tag = cpu_addr[ADDR_SIZE-1 -: TAG_W];
    assign cpu_idx = cpu_addr[OFF_W +: IDX_W];
    assign cpu_off = cpu_addr[OFF_W-1:0];

    // Tag compare across all ways. At most one way can match because a line
    // is only ever installed after a miss on its tag.
    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        cpu_dout = '1;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w][cpu_idx] && (tag_mem[w][cpu_idx] == cpu_tag)) begin
                hit_any  = 1'b1;
                hit_way  = AGE_W'(w);
                cpu_dout = data_mem[w][{cpu_idx, cpu_off}];
            end
        end
    end

    assign cpu_hit = hit_any;

    // Victim choice: the lowest-numbered invalid way first. Otherwise pick
    // the way whose age is the maximum, which marks it as least recently used.
    always_comb begin
        victim_sel   = '0;
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid[w][cpu_idx]) begin
                victim_sel   = AGE_W'(w);
                victim_found = 1'b1;
            end
        end
        if (!victim_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[w][cpu_idx] == OLDEST) begin
                    victim_sel = AGE_W'(w);
                end
            end
        end
    end

    assign hit_access = (state == IDLE) && cpu_rd && hit_any;
    assign start_fill = (state == IDLE) && cpu_rd && !hit_any;
    assign fill_done  = (state == FILL) && mem_ack && (fill_cnt == LAST_WORD);
    assign cpu_stall  = (state == FILL) || (cpu_rd && !hit_any);

    // A hit in IDLE and the end of a fill are mutually exclusive, so one
    // LRU port serves both.
    always_comb begin
        touch_en  = hit_access || fill_done;
        touch_way = fill_done ? victim_way : hit_way;
        touch_idx = fill_done ? fill_idx : cpu_idx;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and memory-side outputs. mem_addr is driven only during
    // FILL, so it reads zero in IDLE and under reset.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_addr   = '0;
        case (state)
            IDLE: begin
                if (start_fill) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {fill_tag, fill_idx, fill_cnt};
                if (fill_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Valid bits, ages and fill bookkeeping. A flush seen during a fill is
    // held in flush_pending. When the fill completes, the flush wipes every
    // line, including the freshly filled one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
                for (int s = 0; s < LINES_PER_SET; s++) begin
                    age[w][s] <= AGE_W'(w);
                end
            end
            fill_tag      <= '0;
            fill_idx      <= '0;
            fill_cnt      <= '0;
            victim_way    <= '0;
            flush_pending <= 1'b0;
        end else begin
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGE_W'(w) == touch_way) begin
                        age[w][touch_idx] <= '0;
                    end else if (age[w][touch_idx] < age[touch_way][touch_idx]) begin
                        age[w][touch_idx] <= age[w][touch_idx] + 1'b1;
                    end
                end
            end

            if (start_fill) begin
                fill_tag   <= cpu_tag;
                fill_idx   <= cpu_idx;
                fill_cnt   <= '0;
                victim_way <= victim_sel;
                valid[victim_sel][cpu_idx] <= 1'b0;
            end

            if ((state == FILL) && mem_ack) begin
                fill_cnt <= fill_cnt + 1'b1;
            end

            if ((state == FILL) && flush && !fill_done) begin
                flush_pending <= 1'b1;
            end

            if (fill_done) begin
                if (flush_pending || flush) begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid[w] <= '0;
                    end
                    flush_pending <= 1'b0;
                end else begin
                    valid[victim_way][fill_idx] <= 1'b1;
                end
            end

            if ((state == IDLE) && flush) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[w] <= '0;
                end
            end
        end
    end

    // Tag and data arrays: plain synchronous writes, no reset.
    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_ack) begin
            data_mem[victim_way][{fill_idx, fill_cnt}] <= mem_data;
        end
        if (fill_done) begin
            tag_mem[victim_way][fill_idx] <= fill_tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    // Performance counters wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_access) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (start_fill) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_nway.sv
// ---------------------------------------------------------------------------
// tb_icache_nway
// Self-checking bench for icache_nway at default parameters.
// The bench computes every expected result from its own data:
//   - Expected fill addresses go into addr_q when a fill starts. The monitor
//     pops one entry for each cycle in which mem_req and mem_ack are both high.
//   - Expected hit data goes into data_q when a read that should hit is
//     issued. The monitor pops one entry for each cycle in which cpu_rd and
//     cpu_hit are both high.
// The memory returns model(addr) for every address.
// ---------------------------------------------------------------------------
module tb_icache_nway;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int WPL = 8;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          cpu_rd   = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          flush    = 1'b0;
    logic          mem_ack  = 1'b0;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] cpu_dout;
    logic          cpu_hit;
    logic          cpu_stall;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] data_q[$];

    logic          p_hit;
    logic [DW-1:0] p_dout;
    int            f_acks;
    int            f_cycles;
    bit            f_stall_ok;
    bit            f_addr_stable;

    icache_nway dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_rd     (cpu_rd),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_hit    (cpu_hit),
        .cpu_stall  (cpu_stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model(input logic [AW-1:0] a);
        return {a, 2'b10, ~a, 2'b01};
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset && mem_req && mem_ack) begin
            checks++;
            if (addr_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL fill_addr: got unexpected ack at %h, expected no fetch", mem_addr);
            end else begin
                logic [AW-1:0] ea;
                ea = addr_q.pop_front();
                if (mem_addr !== ea) begin
                    errors++;
                    $display("[TB] FAIL fill_addr: got %h expected %h", mem_addr, ea);
                end
            end
        end
        if (!reset && cpu_rd && cpu_hit) begin
            checks++;
            if (data_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL hit_data: got unexpected hit at %h, expected miss", cpu_addr);
            end else begin
                logic [DW-1:0] ed;
                ed = data_q.pop_front();
                if (cpu_dout !== ed) begin
                    errors++;
                    $display("[TB] FAIL hit_data: addr %h got %h expected %h", cpu_addr, cpu_dout, ed);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_read(input logic [AW-1:0] a, input bit exp_hit);
        cpu_rd   = 1'b1;
        cpu_addr = a;
        if (exp_hit) data_q.push_back(model(a));
        #1;
    endtask

    task automatic end_read;
        step;
        cpu_rd = 1'b0;
    endtask

    // Looks at the hit outputs without letting a clock edge see the request.
    task automatic probe(input logic [AW-1:0] a);
        cpu_rd   = 1'b1;
        cpu_addr = a;
        #1;
        p_hit  = cpu_hit;
        p_dout = cpu_dout;
        cpu_rd = 1'b0;
        #1;
    endtask

    // Next-level memory responder. It acks on every gap-th cycle, pulses
    // flush together with ack number flush_ack, and stops after abort_after
    // acks. cpu_rd is released together with the last ack.
    task automatic fill_line(input logic [AW-1:0] base, input int gap, input int flush_ack,
                             input int abort_after);
        logic [AW-1:0] prev_addr;
        bit            prev_ack;
        int            n_push;
        f_acks        = 0;
        f_cycles      = 0;
        f_stall_ok    = 1'b1;
        f_addr_stable = 1'b1;
        prev_ack      = 1'b1;
        prev_addr     = '0;
        n_push        = (abort_after < WPL) ? abort_after : WPL;
        for (int i = 0; i < n_push; i++) addr_q.push_back({base[AW-1:3], 3'b000} + AW'(i));
        while (f_cycles < 400) begin
            step;
            mem_ack = 1'b0;
            flush   = 1'b0;
            if (!mem_req || f_acks >= abort_after) break;
            if (!cpu_stall) f_stall_ok = 1'b0;
            if (!prev_ack && mem_addr !== prev_addr) f_addr_stable = 1'b0;
            prev_addr = mem_addr;
            if ((f_cycles % gap) == gap - 1) begin
                mem_ack  = 1'b1;
                mem_data = model(mem_addr);
                f_acks++;
                if (f_acks == flush_ack) flush = 1'b1;
                if (f_acks == WPL) cpu_rd = 1'b0;
            end
            prev_ack = mem_ack;
            f_cycles++;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        cpu_rd = 1'b0;
        reset  = 1'b1;
        step;
        step;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== '0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (cpu_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit: got %b expected 0", cpu_hit); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_idle: got %b expected 0", cpu_stall); end
        checks++; if (cpu_dout !== '1) begin errors++; $display("[TB] FAIL reset_dout: got %h expected ffffffff", cpu_dout); end
        cpu_rd = 1'b1;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall_rd: got %b expected 1", cpu_stall); end
        cpu_rd = 1'b0;
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", hit_count, miss_count); end
        reset = 1'b0;
        step;
    endtask

    task automatic test_basic_fill;
        start_read(14'h0100, 1'b0);
        checks++; if (cpu_hit !== 1'b0) begin errors++; $display("[TB] FAIL basic_miss: got %b expected 0", cpu_hit); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL basic_stall: got %b expected 1", cpu_stall); end
        checks++; if (cpu_dout !== '1) begin errors++; $display("[TB] FAIL basic_miss_dout: got %h expected ffffffff", cpu_dout); end
        fill_line(14'h0100, 1, 0, 99);
        checks++; if (f_acks !== WPL) begin errors++; $display("[TB] FAIL basic_acks: got %0d expected %0d", f_acks, WPL); end
        checks++; if (f_cycles !== WPL) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", f_cycles, WPL); end
        checks++; if (f_stall_ok !== 1'b1) begin errors++; $display("[TB] FAIL basic_fill_stall: got %b expected 1", f_stall_ok); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_req: got %b expected 0", mem_req); end
        start_read(14'h0100, 1'b1);
        checks++; if (cpu_hit !== 1'b1) begin errors++; $display("[TB] FAIL basic_refetch_hit: got %b expected 1", cpu_hit); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL basic_refetch_stall: got %b expected 0", cpu_stall); end
        end_read;
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] offs [4] = '{14'h0103, 14'h0107, 14'h0101, 14'h0106};
        for (int i = 0; i < 4; i++) begin
            start_read(offs[i], 1'b1);
            checks++; if (cpu_hit !== 1'b1) begin errors++; $display("[TB] FAIL b2b_hit: addr %h got %b expected 1", offs[i], cpu_hit); end
            if (i < 3) step;
        end
        end_read;
        mem_ack  = 1'b1;
        mem_data = 32'hDEADBEEF;
        step;
        step;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_ack_req: got %b expected 0", mem_req); end
        mem_ack = 1'b0;
        probe(14'h0102);
        checks++; if (p_hit !== 1'b1 || p_dout !== model(14'h0102)) begin errors++; $display("[TB] FAIL idle_ack_ignored: got %b/%h expected 1/%h", p_hit, p_dout, model(14'h0102)); end
        step;
    endtask

    task automatic test_lru_evict;
        start_read(14'h1100, 1'b0);
        checks++; if (cpu_hit !== 1'b0) begin errors++; $display("[TB] FAIL lru_miss_1100: got %b expected 0", cpu_hit); end
        fill_line(14'h1100, 1, 0, 99);
        start_read(14'h1100, 1'b1);
        step;
        start_read(14'h0100, 1'b1);
        end_read;
        start_read(14'h2100, 1'b0);
        checks++; if (cpu_hit !== 1'b0) begin errors++; $display("[TB] FAIL lru_miss_2100: got %b expected 0", cpu_hit); end
        fill_line(14'h2100, 1, 0, 99);
        start_read(14'h2100, 1'b1);
        checks++; if (cpu_hit !== 1'b1) begin errors++; $display("[TB] FAIL lru_hit_2100: got %b expected 1", cpu_hit); end
        step;
        start_read(14'h0104, 1'b1);
        checks++; if (cpu_hit !== 1'b1) begin errors++; $display("[TB] FAIL lru_keep_0100: got %b expected 1", cpu_hit); end
        end_read;
        probe(14'h1100);
        checks++; if (p_hit !== 1'b0) begin errors++; $display("[TB] FAIL lru_evicted_1100: got %b expected 0", p_hit); end
        step;
    endtask

    task automatic test_gapped;
        start_read(14'h0340, 1'b0);
        fill_line(14'h0340, 3, 0, 99);
        checks++; if (f_acks !== WPL) begin errors++; $display("[TB] FAIL gap_acks: got %0d expected %0d", f_acks, WPL); end
        checks++; if (f_cycles !== 3 * WPL) begin errors++; $display("[TB] FAIL gap_cycles: got %0d expected %0d", f_cycles, 3 * WPL); end
        checks++; if (f_stall_ok !== 1'b1) begin errors++; $display("[TB] FAIL gap_stall: got %b expected 1", f_stall_ok); end
        checks++; if (f_addr_stable !== 1'b1) begin errors++; $display("[TB] FAIL gap_addr_stable: got %b expected 1", f_addr_stable); end
        start_read(14'h0340, 1'b1);
        step;
        start_read(14'h0345, 1'b1);
        checks++; if (cpu_hit !== 1'b1) begin errors++; $display("[TB] FAIL gap_hit: got %b expected 1", cpu_hit); end
        end_read;
    endtask

    task automatic test_flush;
        start_read(14'h0200, 1'b0);
        fill_line(14'h0200, 1, 4, 99);
        checks++; if (f_acks !== WPL) begin errors++; $display("[TB] FAIL flush_fill_acks: got %0d expected %0d", f_acks, WPL); end
        probe(14'h0200);
        checks++; if (p_hit !== 1'b0) begin errors++; $display("[TB] FAIL flush_fill_line: got %b expected 0", p_hit); end
        probe(14'h0100);
        checks++; if (p_hit !== 1'b0) begin errors++; $display("[TB] FAIL flush_pending_old: got %b expected 0", p_hit); end
        probe(14'h0340);
        checks++; if (p_hit !== 1'b0 || p_dout !== '1) begin errors++; $display("[TB] FAIL flush_pending_set8: got %b/%h expected 0/ffffffff", p_hit, p_dout); end
        step;
        start_read(14'h0400, 1'b0);
        fill_line(14'h0400, 1, 0, 99);
        start_read(14'h0400, 1'b1);
        checks++; if (cpu_hit !== 1'b1) begin errors++; $display("[TB] FAIL flush_refill_hit: got %b expected 1", cpu_hit); end
        end_read;
        flush = 1'b1;
        step;
        flush = 1'b0;
        probe(14'h0400);
        checks++; if (p_hit !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle: got %b expected 0", p_hit); end
        step;
    endtask

    task automatic test_reset_mid_fill;
        start_read(14'h0100, 1'b0);
        fill_line(14'h0100, 1, 0, 99);
        start_read(14'h0100, 1'b1);
        end_read;
        start_read(14'h0500, 1'b0);
        fill_line(14'h0500, 1, 0, 3);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL midfill_req: got %b expected 1", mem_req); end
        reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL midfill_reset_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== '0) begin errors++; $display("[TB] FAIL midfill_reset_addr: got %h expected 0", mem_addr); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL midfill_reset_stall: got %b expected 1", cpu_stall); end
        cpu_rd = 1'b0;
        step;
        step;
        reset = 1'b0;
        step;
        probe(14'h0100);
        checks++; if (p_hit !== 1'b0 || p_dout !== '1) begin errors++; $display("[TB] FAIL midfill_lines_lost: got %b/%h expected 0/ffffffff", p_hit, p_dout); end
        step;
    endtask

    task automatic test_perf;
        logic [31:0] exp_hits;
        logic [31:0] exp_miss;
`ifdef ICACHE_PERF_CNT_EN
        exp_hits = 32'd8;
        exp_miss = 32'd1;
`else
        exp_hits = 32'd0;
        exp_miss = 32'd0;
`endif
        reset = 1'b1;
        step;
        reset = 1'b0;
        step;
        start_read(14'h0600, 1'b0);
        fill_line(14'h0600, 1, 0, 99);
        start_read(14'h0600, 1'b1);
        for (int i = 1; i < WPL; i++) begin
            step;
            start_read(14'h0600 + AW'(i), 1'b1);
        end
        end_read;
        step;
        checks++; if (miss_count !== exp_miss) begin errors++; $display("[TB] FAIL perf_miss: got %0d expected %0d", miss_count, exp_miss); end
        checks++; if (hit_count !== exp_hits) begin errors++; $display("[TB] FAIL perf_hit: got %0d expected %0d", hit_count, exp_hits); end
    endtask

    task automatic test_drain;
        checks++;
        if (addr_q.size() != 0 || data_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", addr_q.size(), data_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_basic_fill;
        test_back_to_back;
        test_lru_evict;
        test_gapped;
        test_flush;
        test_reset_mid_fill;
        test_perf;
        test_drain;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
